mem_bus_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_wdt.sv | 32 +++
 rtl/mem_bus_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-master Wishbone memory-port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 32;
    localparam int SEL_W          = 4;
    localparam int WDT_CYCLES_DEF = 256;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_GNT0 = 2'b01;
    localparam logic [1:0] ST_GNT1 = 2'b10;

    // Encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        GNT0 = ST_GNT0,
        GNT1 = ST_GNT1
    } arb_state_t;

endpackage

// File: rtl/mem_arb_wdt.sv
// Stall watchdog: counts stb-without-ack cycles and fires on the WDT_CYCLES-th one.
`ifdef MEM_ARB_WDT_EN
module mem_arb_wdt
    import mem_arb_pkg::*;
#(
    parameter int WDT_CYCLES = WDT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic cnt_en,
    output logic fire
);

    localparam int CW = $clog2(WDT_CYCLES + 1);

    logic [CW-1:0] cnt;

    assign fire = cnt_en && (cnt == CW'(WDT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || fire) begin
            cnt <= '0;
        end else if (cnt_en) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule
`endif

// File: rtl/mem_bus_arbiter.sv
// Two-master Wishbone classic arbiter: one-cycle grant latency, owner keeps the port until it drops cyc.
// Optional stall watchdog (MEM_ARB_WDT_EN) aborts an owner whose stb goes unacked for WDT_CYCLES.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter bit RR_EN      = 1'b1,
    parameter int WDT_CYCLES = WDT_CYCLES_DEF,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [SEL_W-1:0]  m0_sel_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [SEL_W-1:0]  m1_sel_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic [DATA_W-1:0] m_data_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [SEL_W-1:0]  s_sel_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [DATA_W-1:0] s_data_o,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic              s_ack_i,
    output logic [1:0]        grant_o,
    output logic [CNT_W-1:0]  m0_xfer_cnt_o,
    output logic [CNT_W-1:0]  m1_xfer_cnt_o
);

    arb_state_t state;
    logic       last_grant;
    logic [1:0] req;
    logic       wdt_fire;

    assign grant_o  = state;
    assign m_data_o = s_data_i;

    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_addr_o = '0;
        s_data_o = '0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        unique case (state)
            GNT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_addr_o = m0_addr_i;
                s_data_o = m0_data_i;
                m0_ack_o = s_ack_i;
            end
            GNT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_addr_o = m1_addr_i;
                s_data_o = m1_data_i;
                m1_ack_o = s_ack_i;
            end
            default: ;
        endcase
    end

    // Grants only leave through IDLE, which gives the mandatory dead cycle between owners.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req[0] && req[1]) begin
                        if (RR_EN && !last_grant) begin
                            state      <= GNT1;
                            last_grant <= 1'b1;
                        end else begin
                            state      <= GNT0;
                            last_grant <= 1'b0;
                        end
                    end else if (req[0]) begin
                        state      <= GNT0;
                        last_grant <= 1'b0;
                    end else if (req[1]) begin
                        state      <= GNT1;
                        last_grant <= 1'b1;
                    end
                end
                GNT0: if (!m0_cyc_i || wdt_fire) state <= IDLE;
                GNT1: if (!m1_cyc_i || wdt_fire) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m0_xfer_cnt_o <= '0;
            m1_xfer_cnt_o <= '0;
        end else begin
            if (state == GNT0 && s_stb_o && s_ack_i) m0_xfer_cnt_o <= m0_xfer_cnt_o + CNT_W'(1);
            if (state == GNT1 && s_stb_o && s_ack_i) m1_xfer_cnt_o <= m1_xfer_cnt_o + CNT_W'(1);
        end
    end

`ifdef MEM_ARB_WDT_EN
    logic [1:0] blocked;
    logic       wdt_clr;
    logic       wdt_cnt_en;

    assign wdt_clr    = (state == IDLE) || s_ack_i;
    assign wdt_cnt_en = (state != IDLE) && s_stb_o && !s_ack_i;

    mem_arb_wdt #(
        .WDT_CYCLES (WDT_CYCLES)
    ) u_wdt (
        .clk    (clk),
        .rst    (rst),
        .clr    (wdt_clr),
        .cnt_en (wdt_cnt_en),
        .fire   (wdt_fire)
    );

    assign m0_err_o = wdt_fire && (state == GNT0);
    assign m1_err_o = wdt_fire && (state == GNT1);

    // A faulted master sits out arbitration until it has shown one cycle with cyc low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blocked <= 2'b00;
        end else begin
            if (m0_err_o)       blocked[0] <= 1'b1;
            else if (!m0_cyc_i) blocked[0] <= 1'b0;
            if (m1_err_o)       blocked[1] <= 1'b1;
            else if (!m1_cyc_i) blocked[1] <= 1'b0;
        end
    end

    assign req = {m1_cyc_i && !blocked[1], m0_cyc_i && !blocked[0]};
`else
    assign wdt_fire = 1'b0;
    assign m0_err_o = 1'b0;
    assign m1_err_o = 1'b0;
    assign req      = {m1_cyc_i, m0_cyc_i};
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench: round-robin instance (a) and fixed-priority, 4-bit-counter instance (b) share all inputs.
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_ack;
    logic [3:0]  m0_sel, m1_sel;
    logic [31:0] m0_addr, m0_data, m1_addr, m1_data, s_data_in;

    logic        a_m0_ack, a_m0_err, a_m1_ack, a_m1_err, a_s_cyc, a_s_stb, a_s_we;
    logic [3:0]  a_s_sel;
    logic [31:0] a_m_data, a_s_addr, a_s_data;
    logic [1:0]  a_grant;
    logic [15:0] a_cnt0, a_cnt1;

    logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err, b_s_cyc, b_s_stb, b_s_we;
    logic [3:0]  b_s_sel;
    logic [31:0] b_m_data, b_s_addr, b_s_data;
    logic [1:0]  b_grant;
    logic [3:0]  b_cnt0, b_cnt1;

    mem_bus_arbiter #(.RR_EN(1'b1), .WDT_CYCLES(8), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
        .m0_addr_i(m0_addr), .m0_data_i(m0_data), .m0_ack_o(a_m0_ack), .m0_err_o(a_m0_err),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
        .m1_addr_i(m1_addr), .m1_data_i(m1_data), .m1_ack_o(a_m1_ack), .m1_err_o(a_m1_err),
        .m_data_o(a_m_data), .s_cyc_o(a_s_cyc), .s_stb_o(a_s_stb), .s_we_o(a_s_we),
        .s_sel_o(a_s_sel), .s_addr_o(a_s_addr), .s_data_o(a_s_data),
        .s_data_i(s_data_in), .s_ack_i(s_ack), .grant_o(a_grant),
        .m0_xfer_cnt_o(a_cnt0), .m1_xfer_cnt_o(a_cnt1)
    );

    mem_bus_arbiter #(.RR_EN(1'b0), .WDT_CYCLES(8), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
        .m0_addr_i(m0_addr), .m0_data_i(m0_data), .m0_ack_o(b_m0_ack), .m0_err_o(b_m0_err),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
        .m1_addr_i(m1_addr), .m1_data_i(m1_data), .m1_ack_o(b_m1_ack), .m1_err_o(b_m1_err),
        .m_data_o(b_m_data), .s_cyc_o(b_s_cyc), .s_stb_o(b_s_stb), .s_we_o(b_s_we),
        .s_sel_o(b_s_sel), .s_addr_o(b_s_addr), .s_data_o(b_s_data),
        .s_data_i(s_data_in), .s_ack_i(s_ack), .grant_o(b_grant),
        .m0_xfer_cnt_o(b_cnt0), .m1_xfer_cnt_o(b_cnt1)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        s_cyc, s_stb, s_we;
        logic [3:0]  s_sel;
        logic [31:0] s_addr, s_data, m_data;
        logic        m0_ack, m1_ack, m0_err, m1_err;
        logic [1:0]  grant;
        logic [15:0] cnt0, cnt1;
    } obs_t;

    function automatic obs_t obs_a();
        return '{a_s_cyc, a_s_stb, a_s_we, a_s_sel, a_s_addr, a_s_data, a_m_data,
                 a_m0_ack, a_m1_ack, a_m0_err, a_m1_err, a_grant, a_cnt0, a_cnt1};
    endfunction

    function automatic obs_t obs_b();
        return '{b_s_cyc, b_s_stb, b_s_we, b_s_sel, b_s_addr, b_s_data, b_m_data,
                 b_m0_ack, b_m1_ack, b_m0_err, b_m1_err, b_grant, {12'h0, b_cnt0}, {12'h0, b_cnt1}};
    endfunction

    task automatic check_obs(input string name, input int cyc, input obs_t act, input obs_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference: owner -1 = nobody; the slave sees the owner's signals, nothing otherwise.
    function automatic obs_t model_out(input int owner, input logic [15:0] c0, input logic [15:0] c1);
        obs_t e = '0;
        e.m_data = s_data_in;
        e.cnt0   = c0;
        e.cnt1   = c1;
        if (owner == 0) begin
            e.s_cyc = m0_cyc; e.s_stb = m0_stb; e.s_we = m0_we; e.s_sel = m0_sel;
            e.s_addr = m0_addr; e.s_data = m0_data; e.m0_ack = s_ack; e.grant = 2'b01;
        end else if (owner == 1) begin
            e.s_cyc = m1_cyc; e.s_stb = m1_stb; e.s_we = m1_we; e.s_sel = m1_sel;
            e.s_addr = m1_addr; e.s_data = m1_data; e.m1_ack = s_ack; e.grant = 2'b10;
        end
        return e;
    endfunction

    typedef struct {
        logic        m0_cyc, m0_stb;
        logic [31:0] m0_addr;
        logic        m1_cyc, m1_stb;
        logic [31:0] m1_addr;
        logic        ack;
        logic [31:0] rdata;
        logic [1:0]  grant;
        logic        s_cyc;
        logic [31:0] s_addr, s_wdat;
        logic        m0_ack, m1_ack;
        logic [15:0] cnt0, cnt1;
    } vec_t;

    vec_t tbl [12];

    int          own [2];
    int          last [2];
    int unsigned mc0 [2];
    int unsigned mc1 [2];

    task automatic idle_inputs();
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; s_ack = 0; s_data_in = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        m0_we = 1'b1; m0_sel = 4'hF; m0_addr = '0; m0_data = 32'hDEADBEEF;
        m1_we = 1'b0; m1_sel = 4'hF; m1_addr = '0; m1_data = 32'h0BADF00D;

        // Tie out of reset, dead cycle, m1; then m0 single write acked on its 2nd grant cycle.
        tbl[0]  = '{1,1,32'h200, 1,1,32'h300, 0,32'h0,        2'b00,0,32'h0,  32'h0,        0,0, 0,0};
        tbl[1]  = '{1,1,32'h200, 1,1,32'h300, 1,32'hA5A50001, 2'b01,1,32'h200,32'hDEADBEEF, 1,0, 0,0};
        tbl[2]  = '{0,0,32'h200, 1,1,32'h300, 0,32'h0,        2'b01,0,32'h200,32'hDEADBEEF, 0,0, 1,0};
        tbl[3]  = '{0,0,32'h200, 1,1,32'h300, 1,32'h0,        2'b00,0,32'h0,  32'h0,        0,0, 1,0};
        tbl[4]  = '{0,0,32'h200, 1,1,32'h300, 1,32'h12345678, 2'b10,1,32'h300,32'h0BADF00D, 0,1, 1,0};
        tbl[5]  = '{0,0,32'h200, 0,0,32'h300, 0,32'h0,        2'b10,0,32'h300,32'h0BADF00D, 0,0, 1,1};
        tbl[6]  = '{0,0,32'h0,   0,0,32'h0,   0,32'h0,        2'b00,0,32'h0,  32'h0,        0,0, 1,1};
        tbl[7]  = '{1,1,32'h100, 0,0,32'h0,   0,32'h0,        2'b00,0,32'h0,  32'h0,        0,0, 1,1};
        tbl[8]  = '{1,1,32'h100, 0,0,32'h0,   0,32'h0,        2'b01,1,32'h100,32'hDEADBEEF, 0,0, 1,1};
        tbl[9]  = '{1,1,32'h100, 0,0,32'h0,   1,32'hCAFE0000, 2'b01,1,32'h100,32'hDEADBEEF, 1,0, 1,1};
        tbl[10] = '{0,0,32'h100, 0,0,32'h0,   0,32'h0,        2'b01,0,32'h100,32'hDEADBEEF, 0,0, 2,1};
        tbl[11] = '{0,0,32'h100, 0,0,32'h0,   0,32'h0,        2'b00,0,32'h0,  32'h0,        0,0, 2,1};

        @(negedge clk);
        #1;
        check("reset_grant_a", a_grant, 2'b00);
        check("reset_scyc_b", b_s_cyc, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            m0_cyc = tbl[i].m0_cyc; m0_stb = tbl[i].m0_stb; m0_addr = tbl[i].m0_addr;
            m1_cyc = tbl[i].m1_cyc; m1_stb = tbl[i].m1_stb; m1_addr = tbl[i].m1_addr;
            s_ack = tbl[i].ack; s_data_in = tbl[i].rdata;
            #1;
            check($sformatf("tbl%0d grant_a", i), a_grant, tbl[i].grant);
            check($sformatf("tbl%0d grant_b", i), b_grant, tbl[i].grant);
            check($sformatf("tbl%0d s_cyc_a", i), a_s_cyc, tbl[i].s_cyc);
            check($sformatf("tbl%0d s_addr_a", i), a_s_addr, tbl[i].s_addr);
            check($sformatf("tbl%0d s_data_a", i), a_s_data, tbl[i].s_wdat);
            check($sformatf("tbl%0d acks_a", i), {a_m1_ack, a_m0_ack}, {tbl[i].m1_ack, tbl[i].m0_ack});
            check($sformatf("tbl%0d acks_b", i), {b_m1_ack, b_m0_ack}, {tbl[i].m1_ack, tbl[i].m0_ack});
            check($sformatf("tbl%0d m_data_a", i), a_m_data, tbl[i].rdata);
            check($sformatf("tbl%0d cnt_a", i), {a_cnt1, a_cnt0}, {tbl[i].cnt1, tbl[i].cnt0});
            check($sformatf("tbl%0d cnt_b", i), {b_cnt1, b_cnt0}, {tbl[i].cnt1[3:0], tbl[i].cnt0[3:0]});
        end

        // m1 4-beat read burst with m0 requesting mid-burst: no preemption.
        @(negedge clk);
        m1_cyc = 1; m1_stb = 1; m1_addr = 32'h1000; s_ack = 0;
        @(negedge clk);
        #1;
        check("burst_grant_a", a_grant, 2'b10);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            m1_addr = 32'h1000 + 32'(4 * i);
            s_ack = 1; s_data_in = 32'h11 * 32'(i + 1);
            if (i == 1) begin m0_cyc = 1; m0_stb = 1; m0_addr = 32'h40; end
            #1;
            check($sformatf("burst%0d addr_a", i), a_s_addr, 32'h1000 + 32'(4 * i));
            check($sformatf("burst%0d m1_ack_a", i), a_m1_ack, 1'b1);
            check($sformatf("burst%0d m0_ack_a", i), a_m0_ack, 1'b0);
            check($sformatf("burst%0d m_data_a", i), a_m_data, 32'h11 * 32'(i + 1));
            check($sformatf("burst%0d grant_ab", i), {a_grant, b_grant}, 4'b1010);
        end
        @(negedge clk);
        m1_cyc = 0; m1_stb = 0; s_ack = 0; s_data_in = '0;
        #1;
        check("burst_cnt1_a", a_cnt1, 16'd5);
        check("burst_cnt1_b", b_cnt1, 4'd5);
        @(negedge clk);
        #1;
        check("burst_dead_ab", {a_grant, b_grant}, 4'b0000);
        @(negedge clk);
        #1;
        check("burst_m0_next_ab", {a_grant, b_grant}, 4'b0101);

        // Fixed priority (instance b): m0 re-requests inside each dead cycle and keeps winning.
        @(negedge clk);
        m0_cyc = 0; m0_stb = 0;
        @(negedge clk);
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        for (int r = 0; r < 5; r++) begin
            @(negedge clk);
            #1;
            check($sformatf("fixed%0d grant_b", r), b_grant, 2'b01);
            @(negedge clk);
            m0_cyc = 0; m0_stb = 0;
            @(negedge clk);
            m0_cyc = 1; m0_stb = 1;
            #1;
            check($sformatf("fixed%0d dead_b", r), b_grant, 2'b00);
        end
        @(negedge clk);
        #1;
        check("fixed_last_m0_b", b_grant, 2'b01);
        @(negedge clk);
        m0_cyc = 0; m0_stb = 0;
        @(negedge clk);
        #1;
        check("fixed_idle_b", b_grant, 2'b00);
        @(negedge clk);
        #1;
        check("fixed_m1_b", b_grant, 2'b10);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);

        // Asynchronous reset between edges while m1 owns the port.
        @(negedge clk);
        m1_cyc = 1; m1_stb = 1;
        @(negedge clk);
        #1;
        check("pre_rst_grant_ab", {a_grant, b_grant}, 4'b1010);
        check("pre_rst_scyc_a", a_s_cyc, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_scyc_ab", {a_s_cyc, b_s_cyc}, 2'b00);
        check("async_rst_grant_ab", {a_grant, b_grant}, 4'b0000);
        check("async_rst_cnt_a", {a_cnt1, a_cnt0}, 32'h0);
        check("async_rst_cnt_b", {b_cnt1, b_cnt0}, 8'h0);
        @(negedge clk);
        rst = 1'b0;
        m0_cyc = 1; m0_stb = 1;
        @(negedge clk);
        #1;
        check("post_rst_tie_ab", {a_grant, b_grant}, 4'b0101);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);

`ifdef MEM_ARB_WDT_EN
        // Slave never acks m0: error on the 8th stalled cycle, then m1 is served.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("wdt%0d grant_ab", i), {a_grant, b_grant}, 4'b0101);
            check($sformatf("wdt%0d err_a", i), {a_m1_err, a_m0_err}, (i == 8) ? 2'b01 : 2'b00);
            check($sformatf("wdt%0d err_b", i), {b_m1_err, b_m0_err}, (i == 8) ? 2'b01 : 2'b00);
        end
        @(negedge clk);
        #1;
        check("wdt_idle_ab", {a_grant, b_grant, a_s_cyc, b_s_cyc}, 6'b000000);
        @(negedge clk);
        #1;
        check("wdt_m1_next_ab", {a_grant, b_grant}, 4'b1010);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
`endif

        // Randomized traffic against the reference model for both instances.
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            own[k] = -1; last[k] = 1; mc0[k] = 0; mc1[k] = 0;
        end
        begin
            int hold0 = 0;
            int hold1 = 0;
            int stall = 0;
            for (int n = 0; n < 2000; n++) begin
                @(negedge clk);
                if (hold0 == 0) begin m0_cyc = ~m0_cyc; hold0 = $urandom_range(1, 6); end
                if (hold1 == 0) begin m1_cyc = ~m1_cyc; hold1 = $urandom_range(1, 6); end
                hold0--; hold1--;
                m0_stb = m0_cyc & $urandom_range(0, 3) != 0;
                m1_stb = m1_cyc & $urandom_range(0, 3) != 0;
                m0_we = 1'($urandom); m1_we = 1'($urandom);
                m0_sel = 4'($urandom); m1_sel = 4'($urandom);
                m0_addr = $urandom; m1_addr = $urandom;
                m0_data = $urandom; m1_data = $urandom;
                s_data_in = $urandom;
                s_ack = (stall >= 3) ? 1'b1 : 1'($urandom);
                stall = s_ack ? 0 : stall + 1;
                #1;
                for (int k = 0; k < 2; k++) begin
                    obs_t e;
                    int w;
                    if (k == 0) begin
                        e = model_out(own[k], 16'(mc0[k] % 65536), 16'(mc1[k] % 65536));
                        check_obs("rand_rr", n, obs_a(), e);
                    end else begin
                        e = model_out(own[k], 16'(mc0[k] % 16), 16'(mc1[k] % 16));
                        check_obs("rand_fixed", n, obs_b(), e);
                    end
                    if (own[k] == 0) begin
                        if (m0_stb && s_ack) mc0[k]++;
                        if (!m0_cyc) own[k] = -1;
                    end else if (own[k] == 1) begin
                        if (m1_stb && s_ack) mc1[k]++;
                        if (!m1_cyc) own[k] = -1;
                    end else begin
                        w = -1;
                        if (m0_cyc && m1_cyc) w = (k == 0) ? 1 - last[k] : 0;
                        else if (m0_cyc)      w = 0;
                        else if (m1_cyc)      w = 1;
                        if (w >= 0) begin own[k] = w; last[k] = w; end
                    end
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
